// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter for the single register-file read port: grant, select, capture, return.
// Optional RF_ARB_R0_ZERO_EN: a read of address 0 returns zero regardless of the mux output.
module rf_read_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*AW-1:0] i_addr,
  output logic [NREQ-1:0]    o_gnt,
  output logic [AW-1:0]      o_mux_sel,
  input  logic [DW-1:0]      i_mux_data,
  output logic [DW-1:0]      o_rdata,
  output logic [NREQ-1:0]    o_valid,
  output logic               o_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SEL, RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NREQ-1:0]     r_gnt;
  logic [NREQ-1:0]     r_valid;
  logic [AW-1:0]       r_mux_sel;
  logic [DW-1:0]       r_rdata;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_winner;
  logic [NREQ-1:0]     r_served;
  logic [NREQ-1:0]     w_elig;
  logic [IW-1:0]       w_win;
  logic [AW-1:0]       w_win_addr;
  logic                w_take;
  logic [DW-1:0]       w_cap;
  logic [IW-1:0]       w_ptr_nxt;

  // First eligible index at or above ptr, wrapping past NREQ-1.
  function automatic logic [IW-1:0] f_pick(input logic [NREQ-1:0] elig,
                                           input logic [IW-1:0]   ptr);
    logic [IW-1:0] idx;
    logic          found;
    f_pick = ptr;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (!found && elig[idx]) begin
        f_pick = idx;
        found  = 1'b1;
      end
    end
  endfunction

  always_comb begin
    w_elig     = i_req & ~r_served;
    w_win      = f_pick(w_elig, r_rr_ptr);
    w_win_addr = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win == IW'(k)) w_win_addr = i_addr[k*AW +: AW];
    end
    w_take    = (r_state != SEL) && (w_elig != '0);
    w_ptr_nxt = (r_winner == IW'(NREQ - 1)) ? '0 : r_winner + IW'(1);
`ifdef RF_ARB_R0_ZERO_EN
    w_cap = (r_mux_sel == '0) ? '0 : i_mux_data;
`else
    w_cap = i_mux_data;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_take) w_state_nxt = SEL;
      SEL:     w_state_nxt = RESP;
      RESP:    w_state_nxt = w_take ? SEL : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_valid   <= '0;
      r_mux_sel <= '0;
      r_rdata   <= '0;
      r_rr_ptr  <= '0;
      r_winner  <= '0;
      r_served  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        SEL: begin
          r_rdata  <= w_cap;
          r_valid  <= NREQ'(1) << r_winner;
          r_gnt    <= '0;
          r_rr_ptr <= w_ptr_nxt;
          r_served <= NREQ'(1) << r_winner;
        end
        default: begin
          // IDLE and RESP both arbitrate; RESP also retires the previous read.
          r_valid  <= '0;
          r_served <= '0;
          if (w_take) begin
            r_gnt     <= NREQ'(1) << w_win;
            r_mux_sel <= w_win_addr;
            r_winner  <= w_win;
          end
        end
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_valid   = r_valid;
  assign o_mux_sel = r_mux_sel;
  assign o_rdata   = r_rdata;
  assign o_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter: per-cycle vector table plus bounded handshake sequences.
module tb_rf_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [19:0] addr;
  logic [3:0]  gnt;
  logic [4:0]  mux_sel;
  logic [31:0] mux_data;
  logic [31:0] rdata;
  logic [3:0]  valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_read_arbiter #(.NREQ(4), .DW(32), .AW(5)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_req      (req),
    .i_addr     (addr),
    .o_gnt      (gnt),
    .o_mux_sel  (mux_sel),
    .i_mux_data (mux_data),
    .o_rdata    (rdata),
    .o_valid    (valid),
    .o_busy     (busy)
  );

  // Register-file read mux model.
  function automatic logic [31:0] rf_model(input logic [4:0] sel);
    if (sel == 5'd17)     return 32'hDEAD_BEEF;
    else if (sel == 5'd0) return 32'h1234_5678;
    else                  return 32'hC0DE_0000 | {27'd0, sel};
  endfunction
  assign mux_data = rf_model(mux_sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [3:0]  valid;
    logic [4:0]  sel;
    logic [31:0] rdata;
    logic        busy;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl[NV];

  task automatic wait_valid(input string name, input logic [3:0] exp_mask, input int exp_cycles);
    int n;
    n = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      n = c;
      if (valid != 4'b0000) break;
    end
    chk({name, "_latency"}, n, exp_cycles);
    chk({name, "_valid"}, {28'd0, valid}, {28'd0, exp_mask});
    chk({name, "_gnt_clear"}, {28'd0, gnt}, 32'd0);
  endtask

  initial begin
    // reset held with all requesters active
    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 5'd0,  32'h0,         1'b0};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 5'd0,  32'h0,         1'b0};
    // round robin, back-to-back 0,1,2,3,0
    tbl[2]  = '{1'b0, 4'b1111, 4'b0001, 4'b0000, 5'd0,  32'h0,         1'b1};
    tbl[3]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 5'd0,  32'h1234_5678, 1'b1};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0010, 4'b0000, 5'd9,  32'h1234_5678, 1'b1};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0000, 4'b0010, 5'd9,  32'hC0DE_0009, 1'b1};
    tbl[6]  = '{1'b0, 4'b1111, 4'b0100, 4'b0000, 5'd17, 32'hC0DE_0009, 1'b1};
    tbl[7]  = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 5'd17, 32'hDEAD_BEEF, 1'b1};
    tbl[8]  = '{1'b0, 4'b1111, 4'b1000, 4'b0000, 5'd30, 32'hDEAD_BEEF, 1'b1};
    tbl[9]  = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 5'd30, 32'hC0DE_001E, 1'b1};
    tbl[10] = '{1'b0, 4'b1111, 4'b0001, 4'b0000, 5'd0,  32'hC0DE_001E, 1'b1};
    tbl[11] = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 5'd0,  32'h1234_5678, 1'b1};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 5'd0,  32'h1234_5678, 1'b0};
    tbl[13] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 5'd0,  32'h1234_5678, 1'b0};
    // single read from requester 2, addr 17
    tbl[14] = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 5'd17, 32'h1234_5678, 1'b1};
    tbl[15] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 5'd17, 32'hDEAD_BEEF, 1'b1};
    tbl[16] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 5'd17, 32'hDEAD_BEEF, 1'b0};
    // lone repeat requester: one read every 3 cycles
    tbl[17] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 5'd0,  32'hDEAD_BEEF, 1'b1};
    tbl[18] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 5'd0,  32'h1234_5678, 1'b1};
    tbl[19] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 5'd0,  32'h1234_5678, 1'b0};
    tbl[20] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 5'd0,  32'h1234_5678, 1'b1};
    tbl[21] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 5'd0,  32'h1234_5678, 1'b1};
    tbl[22] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 5'd0,  32'h1234_5678, 1'b0};
    // requester 1 drops i_req during SEL and is still served
    tbl[23] = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 5'd9,  32'h1234_5678, 1'b1};
    tbl[24] = '{1'b0, 4'b0000, 4'b0000, 4'b0010, 5'd9,  32'hC0DE_0009, 1'b1};
    tbl[25] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 5'd9,  32'hC0DE_0009, 1'b0};
    // reset during SEL for requester 3 drops the read and rewinds rr_ptr
    tbl[26] = '{1'b0, 4'b1000, 4'b1000, 4'b0000, 5'd30, 32'hC0DE_0009, 1'b1};
    tbl[27] = '{1'b1, 4'b1010, 4'b0000, 4'b0000, 5'd0,  32'h0,         1'b0};
    tbl[28] = '{1'b0, 4'b1010, 4'b0010, 4'b0000, 5'd9,  32'h0,         1'b1};
    tbl[29] = '{1'b0, 4'b1010, 4'b0000, 4'b0010, 5'd9,  32'hC0DE_0009, 1'b1};
    tbl[30] = '{1'b0, 4'b1010, 4'b1000, 4'b0000, 5'd30, 32'hC0DE_0009, 1'b1};
    tbl[31] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 5'd30, 32'hC0DE_001E, 1'b1};
    tbl[32] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 5'd30, 32'hC0DE_001E, 1'b0};

    rst  = 1'b1;
    req  = 4'b0000;
    addr = {5'd30, 5'd17, 5'd9, 5'd0};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      req = tbl[i].req;
      @(posedge clk); #1;
      chk($sformatf("v%0d_gnt", i),   {28'd0, gnt},   {28'd0, tbl[i].gnt});
      chk($sformatf("v%0d_valid", i), {28'd0, valid}, {28'd0, tbl[i].valid});
      chk($sformatf("v%0d_sel", i),   {27'd0, mux_sel}, {27'd0, tbl[i].sel});
      chk($sformatf("v%0d_rdata", i), rdata,          tbl[i].rdata);
      chk($sformatf("v%0d_busy", i),  {31'd0, busy},  {31'd0, tbl[i].busy});
      chk($sformatf("v%0d_overlap", i), {28'd0, gnt & valid}, 32'd0);
    end

    // Two requesters, idle start with rr_ptr=0: 1 first, then 2 back-to-back.
    @(negedge clk);
    req = 4'b0110;
    wait_valid("seq_first", 4'b0010, 2);
    chk("seq_first_rdata", rdata, 32'hC0DE_0009);
    wait_valid("seq_second", 4'b0100, 2);
    chk("seq_second_rdata", rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    req = 4'b0000;
    @(posedge clk); #1;
    chk("seq_idle_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
